// File: rtl/median_window_ctrl.sv
// Window-size controller and 2-entry output buffer for the median filter cell array.
// Sequences clear/fill/run, applies W changes safely and buffers the selected median tap.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`ifndef LOG_WMAX
`define LOG_WMAX 4
`endif
`ifndef WMAX
`define WMAX 9
`endif

module median_window_ctrl #(
  parameter int unsigned DATA_LENGTH = `DATA_LENGTH,
  parameter int unsigned LOG_WMAX    = `LOG_WMAX,
  parameter int unsigned WMAX        = `WMAX,
  parameter int unsigned W_DEFAULT   = WMAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [LOG_WMAX-1:0]    cfg_w,
  output logic                   cfg_err,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic [DATA_LENGTH-1:0] array_X,
  output logic                   array_en,
  output logic                   array_clr,
  output logic [LOG_WMAX-1:0]    array_W,
  output logic [LOG_WMAX-1:0]    med_sel,
  input  logic [DATA_LENGTH-1:0] med_data,
  output logic                   out_valid,
  output logic [DATA_LENGTH-1:0] out_data,
  input  logic                   out_ready
);

  typedef enum logic [1:0] {S_CLEAR, S_FILL, S_RUN, S_APPLY} state_t;

  localparam logic [LOG_WMAX-1:0] W_RST   = LOG_WMAX'(W_DEFAULT);
  localparam logic [LOG_WMAX-1:0] W_LIMIT = LOG_WMAX'(WMAX);
  localparam logic [LOG_WMAX-1:0] ONE     = LOG_WMAX'(1);

  function automatic logic [LOG_WMAX-1:0] tap_of(input logic [LOG_WMAX-1:0] w);
    logic [LOG_WMAX:0] s;
    s = {1'b0, w} + (LOG_WMAX+1)'(1);
    return s[LOG_WMAX:1];
  endfunction

  state_t                   state, state_nx;
  logic [LOG_WMAX-1:0]      w_reg, sel_reg, fill_cnt, pend_w;
  logic                     pend_valid, cap_pend, cfg_err_r;
  logic [DATA_LENGTH-1:0]   buf_mem [2];
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               ocnt;
  logic                     accept, pop, push, cap_nx, fill_last, cfg_bad, run_like;
  logic [2:0]               occ_after;

  // Room is judged after this cycle's pending capture and pop, so a draining
  // sink keeps the input open at full rate.
  always_comb begin
    run_like  = (state == S_FILL) || (state == S_RUN);
    pop       = (ocnt != 2'd0) && out_ready;
    push      = cap_pend;
    occ_after = {1'b0, ocnt} + {2'b00, cap_pend} - {2'b00, pop};
    in_ready  = run_like && !pend_valid && (occ_after < 3'd2);
    accept    = in_valid && in_ready;
    fill_last = (fill_cnt + ONE) == w_reg;
    cap_nx    = accept && ((state == S_RUN) || ((state == S_FILL) && fill_last));
    cfg_bad   = (cfg_w == '0) || (cfg_w > W_LIMIT);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CLEAR: state_nx = S_FILL;
      S_FILL: begin
        if (pend_valid && !cap_pend)  state_nx = S_APPLY;
        else if (accept && fill_last) state_nx = S_RUN;
      end
      S_RUN:   if (pend_valid && !cap_pend) state_nx = S_APPLY;
      S_APPLY: state_nx = S_CLEAR;
      default: state_nx = S_CLEAR;
    endcase
  end

  assign array_clr = (state == S_CLEAR);
  assign array_en  = accept;
  assign array_X   = in_data;
  assign array_W   = w_reg;
  assign med_sel   = sel_reg;
  assign out_valid = (ocnt != 2'd0);
  assign out_data  = buf_mem[rd_ptr];
  assign cfg_err   = cfg_err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CLEAR;
      w_reg      <= W_RST;
      sel_reg    <= tap_of(W_RST);
      fill_cnt   <= '0;
      pend_w     <= '0;
      pend_valid <= 1'b0;
      cap_pend   <= 1'b0;
      cfg_err_r  <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      ocnt       <= '0;
      for (int unsigned i = 0; i < 2; i++) buf_mem[i] <= '0;
    end else begin
      state     <= state_nx;
      cap_pend  <= cap_nx;
      cfg_err_r <= cfg_load && cfg_bad;

      if (cfg_load && !cfg_bad) begin
        pend_valid <= 1'b1;
        pend_w     <= cfg_w;
      end else if (state == S_APPLY) begin
        pend_valid <= 1'b0;
      end

      if (state == S_APPLY) begin
        w_reg   <= pend_w;
        sel_reg <= tap_of(pend_w);
      end

      if (state == S_CLEAR)                fill_cnt <= '0;
      else if (state == S_FILL && accept)  fill_cnt <= fill_cnt + ONE;

      if (push) begin
        buf_mem[wr_ptr] <= med_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   ocnt <= ocnt + 2'd1;
        2'b01:   ocnt <= ocnt - 2'd1;
        default: ocnt <= ocnt;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl with a behavioural cell-array model and
// a scoreboard of expected medians filled at accept time.
module tb_median_window_ctrl;

  localparam int DL = 8;
  localparam int LW = 4;
  localparam int WM = 9;
  localparam int WD = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_load;
  logic [LW-1:0] cfg_w;
  logic          cfg_err;
  logic          in_valid;
  logic [DL-1:0] in_data;
  logic          in_ready;
  logic [DL-1:0] array_X;
  logic          array_en;
  logic          array_clr;
  logic [LW-1:0] array_W;
  logic [LW-1:0] med_sel;
  logic [DL-1:0] med_data = '0;
  logic          out_valid;
  logic [DL-1:0] out_data;
  logic          out_ready;

  median_window_ctrl #(
    .DATA_LENGTH(DL),
    .LOG_WMAX   (LW),
    .WMAX       (WM),
    .W_DEFAULT  (WD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .cfg_w    (cfg_w),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .array_X  (array_X),
    .array_en (array_en),
    .array_clr(array_clr),
    .array_W  (array_W),
    .med_sel  (med_sel),
    .med_data (med_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_w;
  int pops = 0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] hist[$];
  logic [DL-1:0] win[$];
  logic obs_acc, obs_pop, obs_err, obs_clr;

  function automatic logic [DL-1:0] pick(input logic [DL-1:0] q[$], input int k);
    logic [DL-1:0] a[$];
    logic [DL-1:0] t;
    a = q;
    for (int i = 0; i < a.size(); i++)
      for (int j = 0; j + 1 < a.size() - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    if (k < 1 || k > a.size()) return '0;
    return a[k-1];
  endfunction

  // Cell array: holds the last array_W samples, tap med_sel is the k-th smallest.
  always @(posedge clk) begin
    if (array_clr) win.delete();
    else if (array_en) begin
      win.push_back(array_X);
      while (win.size() > int'(array_W)) void'(win.pop_front());
    end
    med_data <= pick(win, int'(med_sel));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic got;
    #1;
    obs_acc = in_valid && in_ready;
    obs_pop = out_valid && out_ready;
    obs_err = cfg_err;
    obs_clr = array_clr;
    if (obs_pop) begin
      pops++;
      got = exp_q.size() > 0;
      check("out_expected", got, 1);
      if (got) check("out_data", out_data, exp_q.pop_front());
    end
    if (obs_acc) begin
      hist.push_back(in_data);
      if (hist.size() > cur_w) void'(hist.pop_front());
      if (hist.size() == cur_w) exp_q.push_back(pick(hist, (cur_w + 1) / 2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DL-1:0] d);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = obs_acc;
    end
    check("send_accepted", done, 1);
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && out_valid === 1'b0) break;
      tick();
    end
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_out_idle"}, out_valid, 0);
  endtask

  task automatic do_cfg(input logic [LW-1:0] w);
    cfg_load = 1'b1;
    cfg_w    = w;
    tick();
    cfg_load = 1'b0;
    hist.delete();
    cur_w = int'(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DL-1:0] t1 [5] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    logic [DL-1:0] t2 [6] = '{8'd4, 8'd8, 8'd6, 8'd2, 8'd2, 8'd9};
    logic [DL-1:0] t3 [4] = '{8'd11, 8'd33, 8'd22, 8'd44};
    logic [DL-1:0] t4 [7] = '{8'd10, 8'd50, 8'd30, 8'd70, 8'd20, 8'd60, 8'd40};
    logic [DL-1:0] t6 [5] = '{8'd20, 8'd80, 8'd40, 8'd60, 8'd10};
    int idx, p0, errs;
    logic prev;

    reset = 1'b0; cfg_load = 1'b0; cfg_w = '0;
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    cur_w = WD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_array_clr", array_clr, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_array_en", array_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_array_W", array_W, WD);
    check("rst_med_sel", med_sel, 3);

    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("clear_cycle_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("fill_ready", in_ready, 1);

    // W=5 first window
    foreach (t1[i]) begin
      send(t1[i]);
      check("t1_no_early_out", out_valid, 0);
    end
    in_valid = 1'b0;
    tick();
    check("t1_latency_valid", out_valid, 1);
    check("t1_first_median", out_data, 5);
    drain("t1");

    // W=3 continuous stream
    do_cfg(4'd3);
    repeat (3) tick();
    check("t2_array_W", array_W, 3);
    check("t2_med_sel", med_sel, 2);
    p0 = pops;
    foreach (t2[i]) begin
      check("t2_ready_held", in_ready, 1);
      send(t2[i]);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("t2_back_to_back_outs", pops - p0, 4);
    drain("t2");

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx = 0;
    repeat (6) begin
      in_data = t3[idx];
      tick();
      if (obs_acc) idx++;
    end
    check("t3_accepts", idx, 2);
    check("t3_full_valid", out_valid, 1);
    check("t3_ready_low", in_ready, 0);
    p0 = pops;
    drain("t3");
    check("t3_drained_count", pops - p0, 2);

    // reconfigure with one output buffered
    out_ready = 1'b0;
    send(8'd55);
    in_valid = 1'b0;
    tick();
    check("t4_buffered", out_valid, 1);
    do_cfg(4'd7);
    out_ready = 1'b1;
    obs_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_clr) break;
    end
    check("t4_clr_seen", obs_clr, 1);
    check("t4_clr_one_cycle", array_clr, 0);
    check("t4_array_W", array_W, 7);
    check("t4_med_sel", med_sel, 4);
    check("t4_old_out_delivered", exp_q.size(), 0);
    foreach (t4[i]) begin
      send(t4[i]);
      if (i < 6) check("t4_no_early_out", out_valid, 0);
    end
    drain("t4");

    // illegal configs while streaming
    prev = 1'b0;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DL'(i * 13 + 5);
      cfg_load = (i == 1) || (i == 3);
      cfg_w    = (i == 1) ? 4'd0 : 4'(WM + 1);
      tick();
      check("t5_stream", obs_acc, 1);
      check("t5_cfg_err", obs_err, prev);
      prev = cfg_load;
      errs += int'(obs_err);
    end
    cfg_load = 1'b0;
    in_valid = 1'b0;
    tick();
    check("t5_cfg_err_last", obs_err, prev);
    errs += int'(obs_err);
    check("t5_err_pulses", errs, 2);
    check("t5_array_W", array_W, 7);
    drain("t5");

    // reset mid-stream with two buffered outputs
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DL'(100 + i);
      tick();
    end
    check("t6_buffered", out_valid, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_async_out_valid", out_valid, 0);
    check("t6_async_clr", array_clr, 1);
    check("t6_async_ready", in_ready, 0);
    exp_q.delete();
    hist.delete();
    cur_w = WD;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_clear_ready", in_ready, 0);
    check("t6_clear_clr", array_clr, 1);
    check("t6_array_W", array_W, WD);
    check("t6_med_sel", med_sel, 3);
    @(posedge clk);
    #1;
    check("t6_ready_back", in_ready, 1);
    check("t6_clr_done", array_clr, 0);
    foreach (t6[i]) send(t6[i]);
    in_valid = 1'b0;
    tick();
    check("t6_median", out_data, 40);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_ctrl.md
# median_window_ctrl

Controller and output buffer for the variable-size median filter cell array. It owns the active window size W, issues the array clear and step enable, and accepts input samples over a valid/ready handshake. It counts the window fill, selects the median tap, and hands medians out through a 2-entry output buffer with a valid/ready handshake. It sits between the stream source/sink and the chain of median cells; the array wrapper's tap mux returns the selected cell's R1 on `med_data`.

## Interface
- `DATA_LENGTH`, default `` `DATA_LENGTH ``: sample width.
- `LOG_WMAX`, default `` `LOG_WMAX ``: width of W, counters and tap index.
- `WMAX`, default `` `WMAX ``: largest legal W; must be at most 2^LOG_WMAX-1.
- `W_DEFAULT`, default `WMAX`: W loaded at reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `cfg_load` input 1: one-cycle request to change W.
- `cfg_w` input LOG_WMAX: requested W, sampled when `cfg_load`=1.
- `cfg_err` output 1: one-cycle pulse, requested W was illegal.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input DATA_LENGTH: sample.
- `in_ready` output 1: sample accepted when `in_valid` and `in_ready` are both 1.
- `array_X` output DATA_LENGTH: sample into the cell array (`in_data` passed through combinationally).
- `array_en` output 1: array step enable, equal to `in_valid & in_ready`.
- `array_clr` output 1: active-high synchronous clear to the cell array.
- `array_W` output LOG_WMAX: active W, driven to every cell.
- `med_sel` output LOG_WMAX: median tap cell number, (W+1)>>1.
- `med_data` input DATA_LENGTH: R1 of cell `med_sel`.
- `out_valid` output 1: buffer head is valid.
- `out_data` output DATA_LENGTH: buffer head.
- `out_ready` input 1: sink accepts the buffer head.

## Operation
- States:
  - CLEAR: `array_clr`=1, `in_ready`=0, fill_cnt←0. Lasts exactly 1 cycle, then FILL.
  - FILL: accepting samples. fill_cnt increments on each accept. The accept that brings fill_cnt to W moves the state to RUN.
  - RUN: every accept produces one median.
  - APPLY: 1 cycle. W←pending W. Then CLEAR.
- An accept produces an output if it occurs in RUN, or if it is the W-th accept in FILL. Such an accept sets cap_pend←1 for the next cycle; otherwise cap_pend←0.
- When cap_pend=1, `med_data` is pushed into the output buffer at the end of that cycle.
- Output buffer: 2-entry FIFO. Pop happens on `out_valid & out_ready`.
- `in_ready`=1 iff state∈{FILL,RUN}, no config is pending, and (ocnt + cap_pend − pop) < 2. This gives a combinational path from `out_ready` to `in_ready`, which is allowed.
- Configuration:
  - `cfg_load` with `cfg_w`=0 or `cfg_w`>WMAX: `cfg_err` pulses the next cycle, and the request is dropped.
  - A legal request is latched as pending; a newer request overwrites an older pending one.
  - The pending request is taken (→APPLY) in the first cycle where cap_pend=0. Samples are not accepted from the cycle after `cfg_load` onward.
  - Buffered outputs are kept and remain deliverable. The partial window is discarded.
- `med_sel` and `array_W` change only on entry to CLEAR.

## Timing
- Reset values while `reset`=0:
  - state=CLEAR.
  - `array_clr`=1, `in_ready`=0, `array_en`=0, `out_valid`=0, `out_data`=0, `cfg_err`=0.
  - `array_W`=W_DEFAULT, `med_sel`=(W_DEFAULT+1)>>1.
  - fill_cnt=0, ocnt=0, cap_pend=0, pending cleared.
- After reset release: CLEAR for 1 cycle, so the first accept can occur in cycle 2.
- Latency: accept in cycle t → cell registers update at the end of t → `med_data` is valid in t+1 → pushed at the end of t+1 → `out_valid` is 1 in t+2.
- Throughput: 1 sample per cycle sustained while `out_ready`=1.
- Simultaneous push and pop: ocnt unchanged. Push into a full buffer is impossible by construction, and the verifier asserts this.
- Reset asserted mid-operation: all state is lost immediately (asynchronous), and buffered outputs are discarded.
- `cfg_load` in the same cycle as an accept: the accept completes and its output is still produced. APPLY follows after cap_pend clears.

## Test plan
- Reset release, W_DEFAULT=5, 5 samples 9,3,7,1,5 with `out_ready`=1 → first `out_valid` 2 cycles after the 5th accept, `out_data`=5, no output before that.
- W=3 stream 4,8,6,2,2,9, `out_ready`=1, `in_valid`=1 continuously → 4 outputs 6,6,2,2 on consecutive cycles, with `in_ready` held at 1.
- W=3 streaming, `out_ready`=0 for 6 cycles → buffer fills to 2 and `in_ready` drops with no lost or duplicated outputs. When `out_ready` returns to 1, the buffered values drain in order.
- `cfg_load` `cfg_w`=7 while RUN with W=3 and 1 output buffered → the buffered output is still delivered. Then APPLY and CLEAR (`array_clr`=1 for 1 cycle), `array_W`=7, `med_sel`=4, and the next output comes only after 7 new accepts.
- `cfg_load` with `cfg_w`=0, then with `cfg_w`=WMAX+1 → `cfg_err` pulses once for each, `array_W` is unchanged, and streaming is uninterrupted.
- `reset` asserted for 1 cycle mid-stream with 2 outputs buffered → `out_valid`=0 asynchronously and `array_clr`=1. Then CLEAR for 1 cycle, `in_ready` returns in the 2nd cycle after release, and W=W_DEFAULT.
